// File: rtl/uart_rgb_pkg.sv
// Shared types and constants for the UART RGB frame assembler.
package uart_rgb_pkg;

  typedef enum logic [2:0] {
    S_HDR = 3'd0,
    S_G   = 3'd1,
    S_R   = 3'd2,
    S_B   = 3'd3,
    S_CS  = 3'd4
  } state_t;

  localparam logic [3:0] DEF_HDR_TAG = 4'hA;
  localparam int         FRAME_LEN   = 5;

  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int R_MSB = 15;
  localparam int R_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  // Frame checksum is a plain XOR over header and colour bytes.
  function automatic logic [7:0] cs_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_rgb_frame_assembler_timeout.sv
// Inter-byte idle counter; tc fires on the last idle cycle a frame may wait.
module frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int            W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_r;

  assign tc = en && (cnt_r == LAST);

  // Idle counter: cleared by a received byte or while waiting for a header.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr || tc) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_rgb_frame_assembler.sv
// Parses HDR,G,R,B,CS byte frames from the UART and updates one of four
// GRB strip registers on a good checksum.
module uart_rgb_frame_assembler
  import uart_rgb_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [3:0] HDR_TAG        = DEF_HDR_TAG,
  parameter int         NUM_STRIPS     = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic [23:0] o_rgb_1,
  output logic [23:0] o_rgb_2,
  output logic [23:0] o_rgb_3,
  output logic [23:0] o_rgb_4,
  output logic [3:0]  o_update,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  state_t                state_r, next_state_s;
  logic [1:0]            idx_r;
  logic [7:0]            g_r, r_r, b_r, xor_r;
  logic [23:0]           rgb_r [NUM_STRIPS];
  logic [NUM_STRIPS-1:0] update_r;
  logic [7:0]            err_cnt_r;

  logic hdr_ok_s, commit_s, cs_bad_s;
  logic tmo_en_s, tmo_clr_s, tmo_tc_s;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (i_clk),
    .rst (i_rst),
    .en  (tmo_en_s),
    .clr (tmo_clr_s),
    .tc  (tmo_tc_s)
  );

  // Next-state decode; a byte strobe always takes priority over the timeout.
  always_comb begin
    next_state_s = state_r;
    hdr_ok_s     = 1'b0;
    commit_s     = 1'b0;
    cs_bad_s     = 1'b0;
    tmo_en_s     = (state_r != S_HDR) && !i_rx_dv;
    tmo_clr_s    = (state_r == S_HDR) || i_rx_dv;
    if (i_rx_dv) begin
      case (state_r)
        S_HDR: begin
          if ((i_rx_byte[7:4] == HDR_TAG) && (i_rx_byte[3:2] == 2'b00)) begin
            hdr_ok_s     = 1'b1;
            next_state_s = S_G;
          end else begin
            next_state_s = S_HDR;
          end
        end
        S_G:     next_state_s = S_R;
        S_R:     next_state_s = S_B;
        S_B:     next_state_s = S_CS;
        S_CS: begin
          next_state_s = S_HDR;
          if (i_rx_byte == xor_r) begin
            commit_s = 1'b1;
          end else begin
            cs_bad_s = 1'b1;
          end
        end
        default: next_state_s = S_HDR;
      endcase
    end else if (tmo_tc_s) begin
      next_state_s = S_HDR;
    end else begin
      next_state_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_HDR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Shadow bytes, running XOR, strip registers and error counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_r     <= 2'd0;
      g_r       <= 8'h00;
      r_r       <= 8'h00;
      b_r       <= 8'h00;
      xor_r     <= 8'h00;
      update_r  <= {NUM_STRIPS{1'b0}};
      err_cnt_r <= 8'h00;
      for (int i = 0; i < NUM_STRIPS; i++) begin
        rgb_r[i] <= 24'h000000;
      end
    end else begin
      update_r <= {NUM_STRIPS{1'b0}};
      if (i_rx_dv) begin
        case (state_r)
          S_HDR: begin
            if (hdr_ok_s) begin
              idx_r <= i_rx_byte[1:0];
              xor_r <= i_rx_byte;
            end
          end
          S_G: begin
            g_r   <= i_rx_byte;
            xor_r <= cs_fold(xor_r, i_rx_byte);
          end
          S_R: begin
            r_r   <= i_rx_byte;
            xor_r <= cs_fold(xor_r, i_rx_byte);
          end
          S_B: begin
            b_r   <= i_rx_byte;
            xor_r <= cs_fold(xor_r, i_rx_byte);
          end
          S_CS: begin
            if (commit_s) begin
              rgb_r[idx_r][G_MSB:G_LSB] <= g_r;
              rgb_r[idx_r][R_MSB:R_LSB] <= r_r;
              rgb_r[idx_r][B_MSB:B_LSB] <= b_r;
              update_r[idx_r]           <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if ((cs_bad_s || tmo_tc_s) && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign o_rgb_1   = rgb_r[0];
  assign o_rgb_2   = rgb_r[1];
  assign o_rgb_3   = rgb_r[2];
  assign o_rgb_4   = rgb_r[3];
  assign o_update  = update_r;
  assign o_busy    = (state_r != S_HDR);
  assign o_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_uart_rgb_frame_assembler.sv
// Directed table-driven bench for uart_rgb_frame_assembler (TIMEOUT_CYCLES = 16).
module tb_uart_rgb_frame_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [23:0] rgb_1, rgb_2, rgb_3, rgb_4;
  logic [3:0]  update;
  logic        busy;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  uart_rgb_frame_assembler #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rx_dv   (rx_dv),
    .i_rx_byte (rx_byte),
    .o_rgb_1   (rgb_1),
    .o_rgb_2   (rgb_2),
    .o_rgb_3   (rgb_3),
    .o_rgb_4   (rgb_4),
    .o_update  (update),
    .o_busy    (busy),
    .o_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] frame;
    logic [3:0]  upd;
    logic [23:0] rgb1;
    logic [23:0] rgb2;
    logic [23:0] rgb3;
    logic [23:0] rgb4;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic drive(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) begin
      drive(f[i*8 +: 8]);
      if (i != 0) idle(1);
    end
  endtask

  task automatic check_all(input string tag, input logic [23:0] r1, input logic [23:0] r2,
                           input logic [23:0] r3, input logic [23:0] r4, input logic [7:0] e);
    check({tag, " rgb_1"}, 32'(rgb_1), 32'(r1));
    check({tag, " rgb_2"}, 32'(rgb_2), 32'(r2));
    check({tag, " rgb_3"}, 32'(rgb_3), 32'(r3));
    check({tag, " rgb_4"}, 32'(rgb_4), 32'(r4));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(e));
  endtask

  initial begin
    vecs[0] = '{40'hA1_10_20_30_A1, 4'b0010, 24'h000000, 24'h102030, 24'h000000, 24'h000000, 8'd0};
    vecs[1] = '{40'hA0_FF_00_00_5F, 4'b0001, 24'hFF0000, 24'h102030, 24'h000000, 24'h000000, 8'd0};
    vecs[2] = '{40'hA3_00_00_FF_5C, 4'b1000, 24'hFF0000, 24'h102030, 24'h000000, 24'h0000FF, 8'd0};
    vecs[3] = '{40'hA2_01_02_03_00, 4'b0000, 24'hFF0000, 24'h102030, 24'h000000, 24'h0000FF, 8'd1};
    vecs[4] = '{40'hA2_01_02_03_A2, 4'b0100, 24'hFF0000, 24'h102030, 24'h010203, 24'h0000FF, 8'd1};
    vecs[5] = '{40'hA1_DE_AD_BE_6C, 4'b0010, 24'hFF0000, 24'hDEADBE, 24'h010203, 24'h0000FF, 8'd1};

    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    idle(3);
    check_all("reset", 24'h0, 24'h0, 24'h0, 24'h0, 8'd0);
    check("reset update", 32'(update), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].frame);
      check($sformatf("vec%0d update", v), 32'(update), 32'(vecs[v].upd));
      check_all($sformatf("vec%0d", v), vecs[v].rgb1, vecs[v].rgb2, vecs[v].rgb3,
                vecs[v].rgb4, vecs[v].err);
      idle(1);
      check($sformatf("vec%0d update pulse end", v), 32'(update), 32'd0);
      check($sformatf("vec%0d busy", v), 32'(busy), 32'd0);
    end

    // Garbage before a frame is dropped without error.
    drive(8'h55); idle(1);
    drive(8'hB1); idle(1);
    drive(8'hA4); idle(1);
    check("garbage busy", 32'(busy), 32'd0);
    send_frame(40'hA1_10_20_30_A1);
    check("garbage update", 32'(update), 32'b0010);
    check_all("garbage", 24'hFF0000, 24'h102030, 24'h010203, 24'h0000FF, 8'd1);

    // Timeout after A0 11 then 16 idle clocks.
    idle(1);
    drive(8'hA0); idle(1);
    drive(8'h11);
    idle(15);
    check("timeout busy before tc", 32'(busy), 32'd1);
    check("timeout err before tc", 32'(err_cnt), 32'd1);
    idle(1);
    check("timeout busy after tc", 32'(busy), 32'd0);
    check("timeout err after tc", 32'(err_cnt), 32'd2);
    send_frame(40'hA0_11_22_33_A0);
    check("post-timeout update", 32'(update), 32'b0001);
    check_all("post-timeout", 24'h112233, 24'h102030, 24'h010203, 24'h0000FF, 8'd2);

    // Byte landing on the terminal idle cycle keeps the frame alive.
    idle(1);
    drive(8'hA0); idle(1);
    drive(8'h11);
    idle(15);
    drive(8'h22);
    check("terminal busy", 32'(busy), 32'd1);
    check("terminal err", 32'(err_cnt), 32'd2);
    idle(1);
    drive(8'h44); idle(1);
    drive(8'hD7);
    check("terminal update", 32'(update), 32'b0001);
    check_all("terminal", 24'h112244, 24'h102030, 24'h010203, 24'h0000FF, 8'd2);

    // Back-to-back bytes with the next header right after the checksum.
    idle(1);
    drive(8'hA1); drive(8'h01); drive(8'h02); drive(8'h03); drive(8'hA1);
    check("b2b first update", 32'(update), 32'b0010);
    check("b2b first rgb_2", 32'(rgb_2), 32'h010203);
    drive(8'hA2);
    check("b2b gap update", 32'(update), 32'd0);
    check("b2b second busy", 32'(busy), 32'd1);
    drive(8'h04); drive(8'h05); drive(8'h06); drive(8'hA5);
    check("b2b second update", 32'(update), 32'b0100);
    check_all("b2b", 24'h112244, 24'h010203, 24'h040506, 24'h0000FF, 8'd2);

    // Reset mid-frame.
    idle(1);
    drive(8'hA1); idle(1);
    drive(8'h10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_all("mid reset", 24'h0, 24'h0, 24'h0, 24'h0, 8'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset update", 32'(update), 32'd0);
    drive(8'h20); idle(1);
    check("mid reset no resume", 32'(busy), 32'd0);

    // Error counter saturation.
    for (int n = 0; n < 300; n++) begin
      send_frame(40'hA2_01_02_03_00);
      idle(1);
      if (n == 99) check("sat err at 100", 32'(err_cnt), 32'd100);
    end
    check("sat err", 32'(err_cnt), 32'hFF);
    check("sat rgb_3", 32'(rgb_3), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
